// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one write port,
// a per-register busy scoreboard for in-flight producers and write-to-read bypass.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n_i,
   input  logic [AW-1:0]   rs1_i,
   input  logic [AW-1:0]   rs2_i,
   output logic [XLEN-1:0] rs1_dat_o,
   output logic [XLEN-1:0] rs2_dat_o,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   rd_i,
   input  logic [XLEN-1:0] rd_dat_i,
   input  logic            iss_en_i,
   input  logic [AW-1:0]   iss_rd_i,
   output logic            stall_o,
   output logic [AW:0]     busy_cnt_o
);

   localparam int NREG = 2 ** AW;

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     cnt_nxt;
   logic            wr_live;
   logic            iss_rd_busy;
   logic            accept;

   function automatic logic is_zero(input logic [AW-1:0] r);
      return ZERO_REG && (r == '0);
   endfunction

   // A write to a hardwired-zero register is dropped entirely.
   assign wr_live = wr_en_i && !is_zero(rd_i);

   // Read data: forwarded writeback beats the stored value; reset forces zero.
   always_comb begin
      rs1_dat_o = regs[rs1_i];
      if (BYPASS && wr_live && (rd_i == rs1_i))
         rs1_dat_o = rd_dat_i;
      if (is_zero(rs1_i) || !rst_n_i)
         rs1_dat_o = '0;
   end

   always_comb begin
      rs2_dat_o = regs[rs2_i];
      if (BYPASS && wr_live && (rd_i == rs2_i))
         rs2_dat_o = rd_dat_i;
      if (is_zero(rs2_i) || !rst_n_i)
         rs2_dat_o = '0;
   end

   // A same-cycle writeback to the register hides its pending busy bit.
   always_comb begin
      rs1_busy_o  = busy[rs1_i] && !(BYPASS && wr_en_i && (rd_i == rs1_i));
      rs2_busy_o  = busy[rs2_i] && !(BYPASS && wr_en_i && (rd_i == rs2_i));
      iss_rd_busy = busy[iss_rd_i] && !(BYPASS && wr_en_i && (rd_i == iss_rd_i));
      if (is_zero(rs1_i))
         rs1_busy_o = 1'b0;
      if (is_zero(rs2_i))
         rs2_busy_o = 1'b0;
      if (is_zero(iss_rd_i))
         iss_rd_busy = 1'b0;
   end

   assign stall_o = iss_en_i && (rs1_busy_o || rs2_busy_o || iss_rd_busy);
   assign accept  = iss_en_i && !stall_o;

   // Setting wins over clearing so a new producer issued in the same cycle
   // as the old one's writeback keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      for (int r = 0; r < NREG; r++) begin
         if (accept && (iss_rd_i == AW'(r)) && !is_zero(AW'(r)))
            busy_nxt[r] = 1'b1;
         else if (wr_en_i && (rd_i == AW'(r)))
            busy_nxt[r] = 1'b0;
         cnt_nxt = cnt_nxt + (AW + 1)'(busy_nxt[r]);
      end
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy       <= '0;
         busy_cnt_o <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_cnt_o <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int r = 0; r < NREG; r++)
            regs[r] <= '0;
      end else if (wr_live) begin
         regs[rd_i] <= rd_dat_i;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expected values are queued when a
// step is driven and popped against DUT outputs when they are sampled.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1, rs2, rd, iss_rd;
   logic [31:0] rs1_dat, rs2_dat, rd_dat;
   logic        rs1_busy, rs2_busy, wr_en, iss_en, stall;
   logic [5:0]  busy_cnt;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic [31:0] mdl [32];
   int          vectors;
   int          miscompares;

   regfile_scoreboard dut (
      .clk        (clk),
      .rst_n_i    (rst_n),
      .rs1_i      (rs1),
      .rs2_i      (rs2),
      .rs1_dat_o  (rs1_dat),
      .rs2_dat_o  (rs2_dat),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy),
      .wr_en_i    (wr_en),
      .rd_i       (rd),
      .rd_dat_i   (rd_dat),
      .iss_en_i   (iss_en),
      .iss_rd_i   (iss_rd),
      .stall_o    (stall),
      .busy_cnt_o (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
         end
      end
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
      rd     = '0;
      rd_dat = '0;
      iss_rd = '0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      rs1 = '0;
      rs2 = '0;
      idle();
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset contents on both ports
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         expect_v("rst_rs1_dat", 32'h0);
         expect_v("rst_rs2_dat", 32'h0);
         expect_v("rst_rs1_busy", 32'h0);
         @(negedge clk);
         check(rs1_dat);
         check(rs2_dat);
         check(32'(rs1_busy));
         #1;
      end
      iss_en = 1'b1; iss_rd = 5'd4; rs1 = 5'd1; rs2 = 5'd2;
      expect_v("rst_stall", 32'h0);
      expect_v("rst_busy_cnt", 32'h0);
      #1;
      check(32'(stall));
      check(32'(busy_cnt));
      iss_en = 1'b0;

      // write-to-read bypass, then held value
      tick();
      wr_en = 1'b1; rd = 5'd5; rd_dat = 32'hDEADBEEF; rs1 = 5'd5;
      mdl[5] = 32'hDEADBEEF;
      expect_v("bypass_same_cycle", 32'hDEADBEEF);
      @(negedge clk);
      check(rs1_dat);
      tick();
      idle();
      expect_v("held_next_cycle", 32'hDEADBEEF);
      expect_v("nonbusy_wb_cnt", 32'h0);
      @(negedge clk);
      check(rs1_dat);
      check(32'(busy_cnt));

      // random writes, read back through port 2
      for (int k = 0; k < 10; k++) begin
         tick();
         wr_en  = 1'b1;
         rd     = 5'($urandom_range(1, 31));
         rd_dat = $urandom;
         mdl[rd] = rd_dat;
      end
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         rs2 = 5'(i);
         expect_v("rand_readback", mdl[i]);
         #2;
         check(rs2_dat);
      end

      // x0 is hardwired zero and never busy
      tick();
      wr_en = 1'b1; rd = 5'd0; rd_dat = 32'h1234;
      iss_en = 1'b1; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      expect_v("x0_bypass_dat", 32'h0);
      expect_v("x0_busy", 32'h0);
      expect_v("x0_stall", 32'h0);
      @(negedge clk);
      check(rs1_dat);
      check(32'(rs1_busy));
      check(32'(stall));
      tick();
      idle();
      expect_v("x0_dat_after", 32'h0);
      expect_v("x0_busy_after", 32'h0);
      expect_v("x0_busy_cnt", 32'h0);
      @(negedge clk);
      check(rs1_dat);
      check(32'(rs1_busy));
      check(32'(busy_cnt));

      // RAW stall on x7, released by same-cycle writeback
      tick();
      iss_en = 1'b1; iss_rd = 5'd7; rs1 = 5'd1; rs2 = 5'd2;
      expect_v("raw_first_issue_stall", 32'h0);
      @(negedge clk);
      check(32'(stall));
      tick();
      iss_en = 1'b1; iss_rd = 5'd0; rs1 = 5'd7; rs2 = 5'd0;
      expect_v("raw_stall", 32'h1);
      expect_v("raw_rs1_busy", 32'h1);
      expect_v("raw_busy_cnt", 32'h1);
      @(negedge clk);
      check(32'(stall));
      check(32'(rs1_busy));
      check(32'(busy_cnt));
      #1;
      wr_en = 1'b1; rd = 5'd7; rd_dat = 32'h55;
      mdl[7] = 32'h55;
      expect_v("raw_wb_stall", 32'h0);
      expect_v("raw_wb_busy", 32'h0);
      expect_v("raw_wb_dat", 32'h55);
      #1;
      check(32'(stall));
      check(32'(rs1_busy));
      check(rs1_dat);
      tick();
      idle();
      expect_v("raw_busy_cnt_zero", 32'h0);
      expect_v("raw_x7_stored", 32'h55);
      @(negedge clk);
      check(32'(busy_cnt));
      check(rs1_dat);

      // issue rd=3 and writeback x3 in one cycle: set wins
      tick();
      iss_en = 1'b1; iss_rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
      wr_en = 1'b1; rd = 5'd3; rd_dat = 32'hA;
      mdl[3] = 32'hA;
      expect_v("setclr_stall", 32'h0);
      @(negedge clk);
      check(32'(stall));
      tick();
      idle();
      rs1 = 5'd3; rs2 = 5'd3;
      expect_v("setclr_dat", 32'hA);
      expect_v("setclr_busy1", 32'h1);
      expect_v("setclr_busy2", 32'h1);
      expect_v("setclr_cnt", 32'h1);
      @(negedge clk);
      check(rs1_dat);
      check(32'(rs1_busy));
      check(32'(rs2_busy));
      check(32'(busy_cnt));
      #1;
      rs1 = 5'd1; rs2 = 5'd2; iss_en = 1'b1; iss_rd = 5'd3;
      expect_v("waw_stall", 32'h1);
      #1;
      check(32'(stall));
      iss_en = 1'b0;
      tick();
      wr_en = 1'b1; rd = 5'd3; rd_dat = 32'hB;
      tick();
      idle();
      expect_v("x3_cleared_cnt", 32'h0);
      @(negedge clk);
      check(32'(busy_cnt));

      // three producers in flight, then asynchronous reset mid-cycle
      for (int k = 0; k < 3; k++) begin
         tick();
         iss_en = 1'b1; iss_rd = 5'(9 + k); rs1 = 5'd1; rs2 = 5'd2;
      end
      tick();
      idle();
      rs1 = 5'd9; rs2 = 5'd11;
      expect_v("inflight_cnt", 32'h3);
      expect_v("inflight_busy9", 32'h1);
      expect_v("inflight_busy11", 32'h1);
      @(negedge clk);
      check(32'(busy_cnt));
      check(32'(rs1_busy));
      check(32'(rs2_busy));
      #2;
      rst_n = 1'b0;
      wr_en = 1'b1; rd = 5'd11; rd_dat = 32'hFFFF_FFFF;
      rs1 = 5'd7;
      expect_v("arst_cnt", 32'h0);
      expect_v("arst_rs1_dat", 32'h0);
      expect_v("arst_rs2_dat", 32'h0);
      expect_v("arst_rs2_busy", 32'h0);
      #1;
      check(32'(busy_cnt));
      check(rs1_dat);
      check(rs2_dat);
      check(32'(rs2_busy));
      tick();
      idle();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(i);
         expect_v("post_rst_dat", 32'h0);
         expect_v("post_rst_busy", 32'h0);
         #1;
         check(rs1_dat);
         check(32'(rs2_busy));
      end
      expect_v("post_rst_cnt", 32'h0);
      @(negedge clk);
      check(32'(busy_cnt));

      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: %0d expected values never compared", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
